// File: rtl/flash_frame_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : flash_frame_loader_pkg
// Purpose  : Shared panel and flash-reader definitions for the frame loader.
//            Holds panel geometry defaults, the RGB565 pixel type, frame
//            buffer address width and SPI flash command field widths.
// Revision : 1.0 - initial release
// ============================================================================
package flash_frame_loader_pkg;

  // Panel geometry defaults (64 x 64)
  localparam int c_LOG_W_DEF = 6;
  localparam int c_LOG_H_DEF = 6;
  localparam int c_FB_ADDR_W = c_LOG_W_DEF + c_LOG_H_DEF;

  // SPI flash reader command fields
  localparam int c_SF_ADDR_W = 24;
  localparam int c_SF_LEN_W  = 16;

  typedef logic [15:0]              rgb565_t;
  typedef logic [c_SF_ADDR_W-1:0]   sf_addr_t;
  typedef logic [c_SF_LEN_W-1:0]    sf_len_t;

  // Flash byte address of a frame; frames are a power-of-two size so the
  // offset is a shift. The sum wraps modulo 2^24 by construction.
  function automatic sf_addr_t frame_start(input sf_addr_t base,
                                           input logic [7:0] frame,
                                           input int unsigned log_frame_bytes);
    return base + (sf_addr_t'(frame) << log_frame_bytes);
  endfunction

endpackage
`default_nettype wire

// File: rtl/flash_pixel_packer.sv
`default_nettype none
// ============================================================================
// Module   : flash_pixel_packer
// Purpose  : Pairs consecutive flash bytes into RGB565 pixels. The even byte
//            of a pair is held as the MSB; the odd byte completes the pixel
//            and produces a one-cycle registered frame buffer write.
// Revision : 1.0 - initial release
// ============================================================================
module flash_pixel_packer
  import flash_frame_loader_pkg::*;
#(
  parameter int LOG_W = c_LOG_W_DEF,
  parameter int LOG_H = c_LOG_H_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_valid,
  input  logic [LOG_W:0]         i_byte_idx,
  input  logic [LOG_H-1:0]       i_line,
  input  logic [7:0]             i_data,
  output logic                   o_we,
  output logic [LOG_W+LOG_H-1:0] o_addr,
  output rgb565_t                o_data
);

  logic                   r_we;
  logic [LOG_W+LOG_H-1:0] r_addr;
  rgb565_t                r_data;
  logic [7:0]             r_msb;

  // Latch the MSB on even bytes, emit the assembled pixel on odd bytes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
      r_msb  <= '0;
    end else begin
      r_we <= i_valid & i_byte_idx[0];
      if (i_valid && !i_byte_idx[0]) begin
        r_msb <= i_data;
      end
      if (i_valid && i_byte_idx[0]) begin
        r_addr <= {i_line, i_byte_idx[LOG_W:1]};
        r_data <= {r_msb, i_data};
      end
    end
  end

  assign o_we   = r_we;
  assign o_addr = r_addr;
  assign o_data = r_data;

endmodule
`default_nettype wire

// File: rtl/flash_frame_loader.sv
`default_nettype none
// ============================================================================
// Module   : flash_frame_loader
// Purpose  : Loads one animation frame from SPI flash into the panel frame
//            buffer per request: one flash read per panel line, bytes packed
//            into RGB565 pixels. Frame index advances and wraps per frame;
//            a request arriving while busy is remembered (single-deep).
// Revision : 1.0 - initial release
// ============================================================================
module flash_frame_loader
  import flash_frame_loader_pkg::*;
#(
  parameter sf_addr_t BASE_ADDR = 24'h100000,
  parameter int       N_FRAMES  = 16,
  parameter int       LOG_W     = c_LOG_W_DEF,
  parameter int       LOG_H     = c_LOG_H_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_frame_req,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [23:0]            o_sf_addr,
  output logic [15:0]            o_sf_len,
  output logic                   o_sf_go,
  input  logic                   i_sf_rdy,
  input  logic [7:0]             i_sf_data,
  input  logic                   i_sf_valid,
  output logic [LOG_W+LOG_H-1:0] o_fbw_addr,
  output logic [15:0]            o_fbw_data,
  output logic                   o_fbw_we
);

  localparam int          c_LINE_BYTES      = 2 << LOG_W;
  localparam int unsigned c_LOG_FRAME_BYTES = LOG_W + LOG_H + 1;
  localparam int          c_BC_W            = LOG_W + 1;

  localparam logic [c_BC_W-1:0] c_LAST_BYTE  = '1;
  localparam logic [LOG_H-1:0]  c_LAST_LINE  = '1;
  localparam logic [7:0]        c_LAST_FRAME = 8'(N_FRAMES - 1);
  localparam sf_addr_t          c_LINE_STEP  = sf_addr_t'(c_LINE_BYTES);

  localparam logic [2:0] c_ST_IDLE   = 3'd0;
  localparam logic [2:0] c_ST_ISSUE  = 3'd1;
  localparam logic [2:0] c_ST_STREAM = 3'd2;
  localparam logic [2:0] c_ST_NEXT   = 3'd3;
  localparam logic [2:0] c_ST_FIN    = 3'd4;

  logic [2:0]        r_state;
  logic              r_pending;
  logic [LOG_H-1:0]  r_line;
  logic [c_BC_W-1:0] r_byte_cnt;
  logic [7:0]        r_frame;
  sf_addr_t          r_sf_addr;

  logic w_start;
  logic w_sf_go;
  logic w_byte_ok;

  assign w_start   = (r_state == c_ST_IDLE) && (i_frame_req || r_pending);
  // Command strobe is combinational so a ready reader accepts in the first
  // ISSUE cycle; it can never assert while the reader is not ready.
  assign w_sf_go   = (r_state == c_ST_ISSUE) && i_sf_rdy;
  // Bytes outside STREAM are neither counted nor written
  assign w_byte_ok = (r_state == c_ST_STREAM) && i_sf_valid;

  // Frame sequencer: line/byte bookkeeping, command address, frame index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= c_ST_IDLE;
      r_line     <= '0;
      r_byte_cnt <= '0;
      r_frame    <= '0;
      r_sf_addr  <= BASE_ADDR;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (w_start) begin
            r_line    <= '0;
            r_sf_addr <= frame_start(BASE_ADDR, r_frame, c_LOG_FRAME_BYTES);
            r_state   <= c_ST_ISSUE;
          end
        end
        c_ST_ISSUE: begin
          if (w_sf_go) begin
            r_byte_cnt <= '0;
            r_state    <= c_ST_STREAM;
          end
        end
        c_ST_STREAM: begin
          if (i_sf_valid) begin
            r_byte_cnt <= r_byte_cnt + 1'b1;
            if (r_byte_cnt == c_LAST_BYTE) begin
              r_state <= c_ST_NEXT;
            end
          end
        end
        c_ST_NEXT: begin
          if (r_line == c_LAST_LINE) begin
            r_state <= c_ST_FIN;
          end else begin
            r_line    <= r_line + 1'b1;
            r_sf_addr <= r_sf_addr + c_LINE_STEP;
            r_state   <= c_ST_ISSUE;
          end
        end
        c_ST_FIN: begin
          r_frame <= (r_frame == c_LAST_FRAME) ? 8'd0 : r_frame + 8'd1;
          r_state <= c_ST_IDLE;
        end
        default: begin
          r_state <= c_ST_IDLE;
        end
      endcase
    end
  end

  // Remember one request made while busy; extra requests merge into it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= 1'b0;
    end else if (w_start) begin
      r_pending <= 1'b0;
    end else if (i_frame_req && (r_state != c_ST_IDLE)) begin
      r_pending <= 1'b1;
    end
  end

  flash_pixel_packer #(
    .LOG_W (LOG_W),
    .LOG_H (LOG_H)
  ) u_packer (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (w_byte_ok),
    .i_byte_idx (r_byte_cnt),
    .i_line     (r_line),
    .i_data     (i_sf_data),
    .o_we       (o_fbw_we),
    .o_addr     (o_fbw_addr),
    .o_data     (o_fbw_data)
  );

  assign o_busy    = (r_state != c_ST_IDLE);
  assign o_done    = (r_state == c_ST_FIN);
  assign o_sf_go   = w_sf_go;
  assign o_sf_addr = r_sf_addr;
  assign o_sf_len  = 16'(c_LINE_BYTES - 1);

endmodule
`default_nettype wire

// File: doc/flash_frame_loader.md
# flash_frame_loader

Sequencer between the SPI flash reader and the RGB panel frame buffer. On each frame request it issues one flash read command per panel line, assembles the returned bytes into RGB565 pixels, and writes them into the frame buffer write port. Animation frames are stored back to back in flash from a base address; the frame index advances and wraps automatically.

## Interface
- BASE_ADDR, 24'h100000, flash byte address of frame 0
- N_FRAMES, 16, number of stored frames (1..256)
- LOG_W, 6, log2 panel width in pixels
- LOG_H, 6, log2 panel height in lines

- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- frame_req  in  1  one-cycle pulse: load next frame
- busy  out  1  high from accepted request to last pixel write
- done  out  1  one-cycle pulse after last pixel of frame written
- sf_addr  out  24  flash read start address
- sf_len  out  16  read length minus one, in bytes
- sf_go  out  1  read command strobe
- sf_rdy  in  1  reader idle, accepts command
- sf_data  in  8  read byte
- sf_valid  in  1  sf_data strobe
- fbw_addr  out  LOG_W+LOG_H  pixel address {line, column}
- fbw_data  out  16  RGB565 pixel
- fbw_we  out  1  pixel write strobe

## Operation
- Constants: LINE_BYTES = 2<<LOG_W, FRAME_BYTES = LINE_BYTES<<LOG_H; sf_len = LINE_BYTES-1 (fixed).
- FSM states: IDLE, ISSUE, STREAM, NEXT, FIN.
  - IDLE: on frame_req or pending flag -> ISSUE; clear pending; line <= 0; sf_addr <= BASE_ADDR + frame*FRAME_BYTES.
  - ISSUE: sf_go = sf_rdy; when sf_go -> STREAM, byte counter <= 0.
  - STREAM: each sf_valid increments byte counter; after byte LINE_BYTES-1 -> NEXT.
  - NEXT: if line == 2^LOG_H-1 -> FIN, else line++, sf_addr += LINE_BYTES -> ISSUE.
  - FIN: done pulse; frame <= (frame == N_FRAMES-1) ? 0 : frame+1; -> IDLE.
- Pixel assembly: even byte is pixel MSB (latched), odd byte is LSB; on odd byte write {msb, sf_data} at {line, byte_cnt[LOG_W:1]}.
- Address arithmetic 24-bit, wraps modulo 2^24; no overflow detection.
- frame_req while busy sets pending (single-deep; further requests merge); pending served from IDLE immediately after FIN.
- sf_valid outside STREAM ignored; no write, no count.
- busy = state != IDLE.

## Timing
- Reset values: sf_go 0, sf_addr BASE_ADDR, fbw_we 0, fbw_addr 0, fbw_data 0, busy 0, done 0; frame 0, pending 0, state IDLE.
- Reset mid-frame: abort immediately, no further writes; reader shares rst so no stale bytes arrive.
- frame_req in IDLE -> ISSUE next cycle; sf_go combinational from state and sf_rdy, so a command accepts in the first ISSUE cycle if sf_rdy high.
- sf_go high exactly one cycle per line; never while sf_rdy low.
- fbw_we registered: asserted the cycle after the odd byte's sf_valid, one cycle wide; fbw_addr/fbw_data valid in that cycle.
- Last write of frame precedes done by at least one cycle; busy drops the cycle after done.
- Per-line overhead: 2 cycles (NEXT, ISSUE) plus reader command latency.

## Structure
- Shared panel package: LOG_W/LOG_H defaults, RGB565 pixel typedef, frame buffer address width; flash interface widths (24-bit addr, 16-bit len).
- Single module; pixel assembler (byte-pair to 16-bit word with write strobe) is a natural sub-module: flash_pixel_packer.

## Test plan
- Bench uses behavioural reader model: rdy low during command, returns byte = (addr+i)[7:0] after 4 cycles, one byte per 8 cycles.
- Reset then frame_req with LOG_W=2, LOG_H=1 -> two commands sf_addr 0x100000, 0x100008, sf_len 7; 8 writes, addr 0..7, first data 0x0001, last 0x0E0F; done once.
- Four requests with N_FRAMES=3 -> frame start addresses 0x100000, 0x100010, 0x100020, 0x100000.
- frame_req pulsed three times mid-frame -> exactly one extra frame loaded right after done; no third.
- Assert rst during line 1 STREAM -> all outputs to reset values same cycle, no fbw_we after; next frame_req restarts at frame 0, line 0.
- BASE_ADDR=24'hFFFFF8, LOG_W=2, LOG_H=1 -> second line command at 0x000000 (wrap); spurious sf_valid in IDLE -> no write.
